// File: rtl/stage_mem_lsu_pkg.sv
// ---------------------------------------------------------------------------
// stage_mem_lsu_pkg
// Shared constants and types for the memory-stage load/store unit. This
// package holds:
//   - the bus widths,
//   - the EX-stage ALU operation codes for loads and stores,
//   - the LSU FSM state encoding,
//   - the access-size encoding,
//   - a decode helper that turns an ALU operation into load/store attributes,
//   - a misalignment helper.
// ---------------------------------------------------------------------------
package stage_mem_lsu_pkg;

    localparam int ALUOP_W   = 8;
    localparam int REG_W     = 32;
    localparam int ADDR_W    = 32;
    localparam int REGADDR_W = 5;
    localparam int DBUS_BE_W = 4;

    // Load/store operation codes as produced by the EX stage
    localparam logic [ALUOP_W-1:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [ALUOP_W-1:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [ALUOP_W-1:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [ALUOP_W-1:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [ALUOP_W-1:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [ALUOP_W-1:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [ALUOP_W-1:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [ALUOP_W-1:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_ACCESS = 2'd1,
        LSU_DONE   = 2'd2,
        LSU_DRAIN  = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } lsu_size_e;

    typedef struct packed {
        logic      isLoad;
        logic      isStore;
        lsu_size_e size;
        logic      isSigned;
    } lsu_op_t;

    // Any operation code that is not listed here is treated as a
    // non-memory instruction: isLoad and isStore both stay 0.
    function automatic lsu_op_t decodeOp(input logic [ALUOP_W-1:0] op);
        lsu_op_t d;
        d.isLoad   = 1'b0;
        d.isStore  = 1'b0;
        d.size     = SIZE_WORD;
        d.isSigned = 1'b0;
        case (op)
            EXE_LB_OP:  begin d.isLoad  = 1'b1; d.size = SIZE_BYTE; d.isSigned = 1'b1; end
            EXE_LBU_OP: begin d.isLoad  = 1'b1; d.size = SIZE_BYTE; end
            EXE_LH_OP:  begin d.isLoad  = 1'b1; d.size = SIZE_HALF; d.isSigned = 1'b1; end
            EXE_LHU_OP: begin d.isLoad  = 1'b1; d.size = SIZE_HALF; end
            EXE_LW_OP:  begin d.isLoad  = 1'b1; d.size = SIZE_WORD; end
            EXE_SB_OP:  begin d.isStore = 1'b1; d.size = SIZE_BYTE; end
            EXE_SH_OP:  begin d.isStore = 1'b1; d.size = SIZE_HALF; end
            EXE_SW_OP:  begin d.isStore = 1'b1; d.size = SIZE_WORD; end
            default:    ;
        endcase
        return d;
    endfunction

    // Alignment rules:
    //   - Halfword accesses must be 2-byte aligned.
    //   - Word accesses must be 4-byte aligned.
    //   - Byte accesses can never be misaligned.
    function automatic logic isMisaligned(input lsu_size_e size, input logic [1:0] addrLow);
        logic mis;
        mis = 1'b0;
        case (size)
            SIZE_HALF: mis = addrLow[0];
            SIZE_WORD: mis = |addrLow;
            default:   mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/stage_mem_lsu_align.sv
// ---------------------------------------------------------------------------
// stage_mem_lsu_align
// Combinational lane logic for the load/store unit. The store side and the
// load side share the same size and address decode.
//   size_i      : access size (lsu_size_e encoding)
//   isSigned_i  : 1 = sign-extend loaded byte/halfword
//   addrLow_i   : low two bits of the effective address
//   storeData_i : register value to be stored
//   loadWord_i  : raw 32-bit word returned by the data bus
//   be_o        : little-endian byte enables
//   wdata_o     : store data replicated into every lane
//   loadData_o  : selected lane, extended to 32 bits
// ---------------------------------------------------------------------------
module stage_mem_lsu_align
    import stage_mem_lsu_pkg::*;
(
    input  logic [1:0]           size_i,
    input  logic                 isSigned_i,
    input  logic [1:0]           addrLow_i,
    input  logic [REG_W-1:0]     storeData_i,
    input  logic [REG_W-1:0]     loadWord_i,
    output logic [DBUS_BE_W-1:0] be_o,
    output logic [REG_W-1:0]     wdata_o,
    output logic [REG_W-1:0]     loadData_o
);

    // Store data is replicated into every lane, so the memory only has to
    // honour the byte enables. The load path picks the lane that the address
    // points at. For halfwords, address bit 0 is ignored: misaligned accesses
    // never reach this point.
    always_comb begin
        logic [7:0]  byteLane;
        logic [15:0] halfLane;
        lsu_size_e   sz;

        sz         = lsu_size_e'(size_i);
        byteLane   = loadWord_i[{addrLow_i, 3'b000} +: 8];
        halfLane   = loadWord_i[{addrLow_i[1], 4'b0000} +: 16];
        be_o       = 4'b1111;
        wdata_o    = storeData_i;
        loadData_o = loadWord_i;

        case (sz)
            SIZE_BYTE: begin
                be_o       = 4'b0001 << addrLow_i;
                wdata_o    = {4{storeData_i[7:0]}};
                loadData_o = isSigned_i ? {{24{byteLane[7]}}, byteLane}
                                        : {24'h000000, byteLane};
            end
            SIZE_HALF: begin
                be_o       = 4'b0011 << {addrLow_i[1], 1'b0};
                wdata_o    = {2{storeData_i[15:0]}};
                loadData_o = isSigned_i ? {{16{halfLane[15]}}, halfLane}
                                        : {16'h0000, halfLane};
            end
            default: begin
                be_o       = 4'b1111;
                wdata_o    = storeData_i;
                loadData_o = loadWord_i;
            end
        endcase
    end

endmodule

// File: rtl/stage_mem_lsu.sv
// ---------------------------------------------------------------------------
// stage_mem_lsu
// Memory-stage load/store unit. It executes EX-stage load/store operations
// against a req/ack data bus and holds the pipeline until each access
// completes. Non-memory instructions pass straight through to WB.
//   clk, rst            : clock and asynchronous active-high reset
//   flush               : abandon the instruction currently in MEM
//   aluop, mem_addr,
//   rt_data             : operation, effective address and store data
//   reg_waddr_i, we_i,
//   reg_wdata_i         : writeback request coming from EX
//   reg_waddr_o, we_o,
//   reg_wdata_o         : writeback request going to WB
//   stallreq            : hold request to pipeline control
//   dbus_*              : registered data-bus request, with ack and read data
//                         coming back
//   misalign_o          : the current operation is misaligned (combinational)
//   bus_err_o           : one-cycle pulse when an access times out
// ---------------------------------------------------------------------------
module stage_mem_lsu
    import stage_mem_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [ALUOP_W-1:0]   aluop,
    input  logic [ADDR_W-1:0]    mem_addr,
    input  logic [REG_W-1:0]     rt_data,
    input  logic [REGADDR_W-1:0] reg_waddr_i,
    input  logic                 we_i,
    input  logic [REG_W-1:0]     reg_wdata_i,
    output logic [REGADDR_W-1:0] reg_waddr_o,
    output logic                 we_o,
    output logic [REG_W-1:0]     reg_wdata_o,
    output logic                 stallreq,
    output logic                 dbus_req,
    output logic                 dbus_we,
    output logic [ADDR_W-1:0]    dbus_addr,
    output logic [DBUS_BE_W-1:0] dbus_be,
    output logic [REG_W-1:0]     dbus_wdata,
    input  logic                 dbus_ack,
    input  logic [REG_W-1:0]     dbus_rdata,
    output logic                 misalign_o,
    output logic                 bus_err_o
);

    localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e           state_q;
    logic                 dbusReq_q;
    logic                 dbusWe_q;
    logic [ADDR_W-1:0]    dbusAddr_q;
    logic [DBUS_BE_W-1:0] dbusBe_q;
    logic [REG_W-1:0]     dbusWdata_q;
    logic [REG_W-1:0]     loadData_q;
    logic                 busErr_q;
    logic                 timedOut_q;
    logic [TIMER_W-1:0]   timer_q;

    lsu_op_t              op;
    logic                 memOp;
    logic                 misaligned;
    logic                 startAccess;
    logic [DBUS_BE_W-1:0] alignBe;
    logic [REG_W-1:0]     alignWdata;
    logic [REG_W-1:0]     alignLoad;

    assign op          = decodeOp(aluop);
    assign memOp       = op.isLoad | op.isStore;
    assign misaligned  = memOp & isMisaligned(op.size, mem_addr[1:0]);
    assign startAccess = memOp & ~misaligned & ~flush;

    stage_mem_lsu_align u_align (
        .size_i      (op.size),
        .isSigned_i  (op.isSigned),
        .addrLow_i   (mem_addr[1:0]),
        .storeData_i (rt_data),
        .loadWord_i  (dbus_rdata),
        .be_o        (alignBe),
        .wdata_o     (alignWdata),
        .loadData_o  (alignLoad)
    );

    // Access sequencer. Each state does the following:
    //   - IDLE:   launches an aligned access.
    //   - ACCESS: waits for the ack. A flush sends it to DRAIN instead,
    //             because the bus transaction must still complete.
    //   - DONE:   lasts one cycle and presents the result to WB.
    // Priority in ACCESS is ack > flush > timeout. A completed access is
    // never thrown away because of a flush or timeout in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LSU_IDLE;
            dbusReq_q   <= 1'b0;
            dbusWe_q    <= 1'b0;
            dbusAddr_q  <= '0;
            dbusBe_q    <= '0;
            dbusWdata_q <= '0;
            loadData_q  <= '0;
            busErr_q    <= 1'b0;
            timedOut_q  <= 1'b0;
            timer_q     <= '0;
        end else begin
            busErr_q <= 1'b0;
            case (state_q)
                LSU_IDLE: begin
                    if (startAccess) begin
                        dbusReq_q   <= 1'b1;
                        dbusWe_q    <= op.isStore;
                        dbusAddr_q  <= {mem_addr[ADDR_W-1:2], 2'b00};
                        dbusBe_q    <= alignBe;
                        dbusWdata_q <= alignWdata;
                        timer_q     <= '0;
                        timedOut_q  <= 1'b0;
                        state_q     <= LSU_ACCESS;
                    end
                end
                LSU_ACCESS: begin
                    if (dbus_ack) begin
                        loadData_q <= alignLoad;
                        dbusReq_q  <= 1'b0;
                        state_q    <= LSU_DONE;
                    end else if (flush) begin
                        state_q <= LSU_DRAIN;
                    end else if ((TIMEOUT_CYCLES != 0) && (timer_q == TIMER_LAST)) begin
                        dbusReq_q  <= 1'b0;
                        busErr_q   <= 1'b1;
                        timedOut_q <= 1'b1;
                        state_q    <= LSU_DONE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                LSU_DONE: begin
                    timedOut_q <= 1'b0;
                    state_q    <= LSU_IDLE;
                end
                LSU_DRAIN: begin
                    if (dbus_ack) begin
                        dbusReq_q <= 1'b0;
                        state_q   <= LSU_IDLE;
                    end
                end
                default: state_q <= LSU_IDLE;
            endcase
        end
    end

    // Writeback and stall path.
    // Stall behaviour:
    //   - IDLE and DRAIN: stall only while an access is waiting to start.
    //   - ACCESS: always stall.
    //   - DONE: release the stall.
    // Writeback behaviour:
    //   - A memory op reports we_o only in DONE, and only for a load that
    //     neither timed out nor was flushed.
    //   - Non-memory ops pass the EX values through unchanged.
    // Reset forces every one of these outputs to 0.
    always_comb begin
        stallreq    = 1'b0;
        we_o        = we_i;
        reg_waddr_o = reg_waddr_i;
        reg_wdata_o = reg_wdata_i;

        case (state_q)
            LSU_IDLE:   stallreq = startAccess;
            LSU_ACCESS: stallreq = 1'b1;
            LSU_DRAIN:  stallreq = startAccess;
            default:    stallreq = 1'b0;
        endcase

        if (memOp) begin
            we_o = 1'b0;
            if ((state_q == LSU_DONE) && op.isLoad) begin
                we_o        = we_i & ~timedOut_q & ~flush;
                reg_wdata_o = loadData_q;
            end
        end

        if (rst) begin
            stallreq    = 1'b0;
            we_o        = 1'b0;
            reg_waddr_o = '0;
            reg_wdata_o = '0;
        end
    end

    assign misalign_o = misaligned & ~rst;
    assign dbus_req   = dbusReq_q;
    assign dbus_we    = dbusWe_q;
    assign dbus_addr  = dbusAddr_q;
    assign dbus_be    = dbusBe_q;
    assign dbus_wdata = dbusWdata_q;
    assign bus_err_o  = busErr_q;

endmodule
